// File: rtl/mux_arb_reg_pkg.sv
// Shared types for the registered arbitrating multiplexer.
// Arbitration mode and packet-lock state encodings.
package mux_pkg;

    typedef enum logic {
        MUX_ARB_PRY = 1'b0,
        MUX_ARB_RR  = 1'b1
    } arb_mode_e;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_st_e;

endpackage

// File: rtl/mux_arb_reg_if.sv
// Request/response bundle for mux_arb_reg.
// slave is the mux side, master the producer/consumer side.
interface mux_arb_reg_if #(
    parameter type DAT_T = logic [3:0],
    parameter int  WIDTH = 4,
    parameter int  IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
);

    logic [WIDTH-1:0] req_vld;
    logic [WIDTH-1:0] req_rdy;
    logic [WIDTH-1:0] req_lst;
    DAT_T [WIDTH-1:0] req_dat;
    logic             out_vld;
    logic             out_rdy;
    logic             out_lst;
    logic [IDX_W-1:0] out_idx;
    DAT_T             out_dat;

    modport master (
        output req_vld, req_lst, req_dat, out_rdy,
        input  req_rdy, out_vld, out_lst, out_idx, out_dat
    );

    modport slave (
        input  req_vld, req_lst, req_dat, out_rdy,
        output req_rdy, out_vld, out_lst, out_idx, out_dat
    );

endinterface

// File: rtl/mux_arb_reg_arb.sv
// Combinational fixed-priority / round-robin arbiter.
// Emits a one-hot grant (or zero) and its encoded index.
module arb_pry_rr
    import mux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MODE  = 0,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [WIDTH-1:0] gnt,
    output logic [IDX_W-1:0] idx
);

    localparam arb_mode_e AM = (MODE != 0) ? MUX_ARB_RR : MUX_ARB_PRY;

    // Later loop iterations overwrite earlier ones, so the last hit wins.
    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        j   = 0;
        if (AM == MUX_ARB_PRY) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (req[i]) begin
                    gnt    = '0;
                    gnt[i] = 1'b1;
                    idx    = IDX_W'(i);
                end
            end
        end else begin
            for (int k = WIDTH - 1; k >= 0; k--) begin
                j = (int'(ptr) + k) % WIDTH;
                if (req[j]) begin
                    gnt    = '0;
                    gnt[j] = 1'b1;
                    idx    = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/mux_arb_reg.sv
// Registered arbitrating multiplexer with optional packet lock.
// One beat per cycle from the granted channel into a single output register.
module mux_arb_reg
    import mux_pkg::*;
#(
    parameter type DAT_T = logic [3:0],
    parameter int  WIDTH = 4,
    parameter int  MODE  = 0,
    parameter int  LOCK  = 0
) (
    input logic          clk,
    input logic          rst,
    mux_arb_reg_if.slave bus
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    lock_st_e         st, st_nxt;
    logic [IDX_W-1:0] lidx, lidx_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] gidx;
    logic [WIDTH-1:0] req, gnt;
    logic             ld, hit, xfer, lst_g;
    DAT_T             dat_g;

    logic             ov, ol;
    logic [IDX_W-1:0] oi;
    DAT_T             od;

    assign ld = !ov || bus.out_rdy;

    // While locked only the owning channel may compete.
    always_comb begin
        req = bus.req_vld;
        if (LOCK != 0 && st == LOCKED)
            req = bus.req_vld & (WIDTH'(1) << lidx);
    end

    arb_pry_rr #(
        .WIDTH (WIDTH),
        .MODE  (MODE),
        .IDX_W (IDX_W)
    ) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gidx)
    );

    assign hit   = |gnt;
    assign lst_g = bus.req_lst[gidx];
    assign dat_g = bus.req_dat[gidx];
    assign xfer  = ld && hit && !rst;

    assign bus.req_rdy = (ld && !rst) ? gnt : '0;

    always_comb begin
        ptr_nxt = ptr;
        if (MODE != 0 && xfer && (LOCK == 0 || lst_g))
            ptr_nxt = (gidx == IDX_W'(WIDTH - 1)) ? '0 : gidx + 1'b1;
    end

    always_comb begin
        st_nxt   = st;
        lidx_nxt = lidx;
        if (LOCK != 0 && xfer) begin
            unique case (st)
                IDLE: begin
                    if (!lst_g) begin
                        st_nxt   = LOCKED;
                        lidx_nxt = gidx;
                    end
                end
                LOCKED: begin
                    if (lst_g)
                        st_nxt = IDLE;
                end
                default: st_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= IDLE;
            lidx <= '0;
            ptr  <= '0;
            ov   <= 1'b0;
            ol   <= 1'b0;
            oi   <= '0;
            od   <= '0;
        end else begin
            st   <= st_nxt;
            lidx <= lidx_nxt;
            ptr  <= ptr_nxt;
            if (ld) begin
                ov <= hit;
                if (hit) begin
                    ol <= lst_g;
                    oi <= gidx;
                    od <= dat_g;
                end
            end
        end
    end

    assign bus.out_vld = ov;
    assign bus.out_lst = ol;
    assign bus.out_idx = oi;
    assign bus.out_dat = od;

endmodule

// File: tb/tb_mux_arb_reg.sv
// Bench for mux_arb_reg: four configurations share one stimulus stream
// and are checked against a per-configuration behavioural model.
module tb_mux_arb_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]       vld  = '0;
    logic [3:0]       lst  = '0;
    logic [3:0][3:0]  dat  = '0;
    logic             ordy = 1'b1;

    mux_arb_reg_if #(.DAT_T(logic [3:0]), .WIDTH(4)) a0 ();
    mux_arb_reg_if #(.DAT_T(logic [3:0]), .WIDTH(4)) a1 ();
    mux_arb_reg_if #(.DAT_T(logic [3:0]), .WIDTH(4)) a2 ();
    mux_arb_reg_if #(.DAT_T(logic [3:0]), .WIDTH(1)) a3 ();

    assign a0.req_vld = vld;
    assign a0.req_lst = lst;
    assign a0.req_dat = dat;
    assign a0.out_rdy = ordy;
    assign a1.req_vld = vld;
    assign a1.req_lst = lst;
    assign a1.req_dat = dat;
    assign a1.out_rdy = ordy;
    assign a2.req_vld = vld;
    assign a2.req_lst = lst;
    assign a2.req_dat = dat;
    assign a2.out_rdy = ordy;
    assign a3.req_vld = vld[0];
    assign a3.req_lst = lst[0];
    assign a3.req_dat[0] = dat[0];
    assign a3.out_rdy = ordy;

    mux_arb_reg #(.DAT_T(logic [3:0]), .WIDTH(4), .MODE(0), .LOCK(0))
        u0 (.clk(clk), .rst(rst), .bus(a0));
    mux_arb_reg #(.DAT_T(logic [3:0]), .WIDTH(4), .MODE(1), .LOCK(0))
        u1 (.clk(clk), .rst(rst), .bus(a1));
    mux_arb_reg #(.DAT_T(logic [3:0]), .WIDTH(4), .MODE(1), .LOCK(1))
        u2 (.clk(clk), .rst(rst), .bus(a2));
    mux_arb_reg #(.DAT_T(logic [3:0]), .WIDTH(1), .MODE(1), .LOCK(0))
        u3 (.clk(clk), .rst(rst), .bus(a3));

    logic [3:0] d_rdy [4];
    logic       d_ov  [4];
    logic       d_ol  [4];
    int         d_oi  [4];
    logic [3:0] d_od  [4];

    always_comb begin
        d_rdy[0] = a0.req_rdy;
        d_rdy[1] = a1.req_rdy;
        d_rdy[2] = a2.req_rdy;
        d_rdy[3] = {3'b000, a3.req_rdy};
        d_ov[0]  = a0.out_vld;
        d_ov[1]  = a1.out_vld;
        d_ov[2]  = a2.out_vld;
        d_ov[3]  = a3.out_vld;
        d_ol[0]  = a0.out_lst;
        d_ol[1]  = a1.out_lst;
        d_ol[2]  = a2.out_lst;
        d_ol[3]  = a3.out_lst;
        d_oi[0]  = int'(a0.out_idx);
        d_oi[1]  = int'(a1.out_idx);
        d_oi[2]  = int'(a2.out_idx);
        d_oi[3]  = int'(a3.out_idx);
        d_od[0]  = a0.out_dat;
        d_od[1]  = a1.out_dat;
        d_od[2]  = a2.out_dat;
        d_od[3]  = a3.out_dat;
    end

    // Model: config c = {MODE0/LOCK0, RR/LOCK0, RR/LOCK1, RR width 1}
    typedef struct {
        int         ptr;
        bit         lk;
        int         li;
        bit         ov;
        bit         ol;
        int         oi;
        logic [3:0] od;
    } mst_t;

    mst_t m  [4];
    mst_t mn [4];
    int mode_c [4] = '{0, 1, 1, 1};
    int lock_c [4] = '{0, 0, 1, 0};
    int w_c    [4] = '{4, 4, 4, 1};

    int errs = 0;
    int chks = 0;

    initial begin
        for (int c = 0; c < 4; c++) m[c] = '{default: 0};
    end

    // Winning channel this cycle, or -1.
    function automatic int pick(int c);
        int w = w_c[c];
        if (m[c].lk) return vld[m[c].li] ? m[c].li : -1;
        if (mode_c[c] == 0) begin
            for (int i = w - 1; i >= 0; i--)
                if (vld[i]) return i;
        end else begin
            for (int k = 0; k < w; k++)
                if (vld[(m[c].ptr + k) % w]) return (m[c].ptr + k) % w;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_rdy(int c);
        int g = pick(c);
        if (rst || (m[c].ov && !ordy) || g < 0) return 4'b0000;
        return 4'(1 << g);
    endfunction

    function automatic mst_t nxt(int c);
        mst_t s = m[c];
        int   g = pick(c);
        if (rst) begin
            s = '{default: 0};
            return s;
        end
        if (!s.ov || ordy) begin
            if (g < 0) begin
                s.ov = 1'b0;
            end else begin
                s.ov = 1'b1;
                s.od = dat[g];
                s.ol = lst[g];
                s.oi = g;
                if (mode_c[c] != 0 && (lock_c[c] == 0 || lst[g]))
                    s.ptr = (g + 1) % w_c[c];
                if (lock_c[c] != 0) begin
                    s.lk = !lst[g];
                    s.li = g;
                end
            end
        end
        return s;
    endfunction

    // Called between negedge and posedge; returns at posedge + 1.
    task automatic step();
        for (int c = 0; c < 4; c++) mn[c] = nxt(c);
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) m[c] = mn[c];
    endtask

    task automatic tick();
        @(negedge clk);
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        vld  = 4'hF;
        lst  = 4'h0;
        ordy = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            chks++;
            if (d_rdy[c] !== 4'b0000) begin
                errs++;
                $display("FAIL reset_rdy c%0d got %b exp 0000", c, d_rdy[c]);
            end
        end
        step();
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            chks++;
            if (d_ov[c] !== 1'b0 || d_ol[c] !== 1'b0 ||
                d_oi[c] !== 0 || d_od[c] !== 4'h0) begin
                errs++;
                $display("FAIL reset_out c%0d got vld=%b lst=%b idx=%0d dat=%h exp 0 0 0 0",
                         c, d_ov[c], d_ol[c], d_oi[c], d_od[c]);
            end
        end
        step();
        rst = 1'b0;
        vld = 4'h0;
        tick();
    endtask

    task automatic test_pry();
        do_reset();
        vld  = 4'b0101;
        ordy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            dat = {$urandom, $urandom};
            @(negedge clk);
            chks++;
            if (d_rdy[0] !== 4'b0100) begin
                errs++;
                $display("FAIL pry_rdy got %b exp 0100", d_rdy[0]);
            end
            step();
            chks++;
            if (d_ov[0] !== 1'b1 || d_oi[0] !== 2 || d_od[0] !== dat[2]) begin
                errs++;
                $display("FAIL pry_out got vld=%b idx=%0d dat=%h exp 1 2 %h",
                         d_ov[0], d_oi[0], d_od[0], dat[2]);
            end
        end
        vld = 4'h0;
    endtask

    task automatic test_rr();
        do_reset();
        vld  = 4'hF;
        lst  = 4'hF;
        ordy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dat = {$urandom, $urandom};
            tick();
            for (int c = 1; c < 3; c++) begin
                chks++;
                if (d_ov[c] !== 1'b1 || d_oi[c] !== i % 4 ||
                    d_od[c] !== dat[i % 4]) begin
                    errs++;
                    $display("FAIL rr_seq c%0d beat %0d got vld=%b idx=%0d dat=%h exp 1 %0d %h",
                             c, i, d_ov[c], d_oi[c], d_od[c], i % 4, dat[i % 4]);
                end
            end
        end
        vld = 4'h0;
    endtask

    task automatic test_stall();
        logic [3:0] exp_d;
        do_reset();
        vld  = 4'hF;
        lst  = 4'hF;
        ordy = 1'b1;
        dat  = {$urandom, $urandom};
        exp_d = dat[1];
        tick();
        tick();
        ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dat = {$urandom, $urandom};
            @(negedge clk);
            chks++;
            if (d_rdy[1] !== 4'b0000 || d_oi[1] !== 1 ||
                d_od[1] !== exp_d || d_ov[1] !== 1'b1) begin
                errs++;
                $display("FAIL stall_hold cyc %0d got rdy=%b idx=%0d dat=%h exp 0000 1 %h",
                         i, d_rdy[1], d_oi[1], d_od[1], exp_d);
            end
            step();
        end
        ordy = 1'b1;
        @(negedge clk);
        chks++;
        if (d_rdy[1] !== 4'b0100) begin
            errs++;
            $display("FAIL stall_resume_rdy got %b exp 0100", d_rdy[1]);
        end
        step();
        chks++;
        if (d_oi[1] !== 2 || d_od[1] !== dat[2]) begin
            errs++;
            $display("FAIL stall_resume_out got idx=%0d dat=%h exp 2 %h",
                     d_oi[1], d_od[1], dat[2]);
        end
        vld = 4'h0;
    endtask

    task automatic test_lock();
        int exp_i [4] = '{1, 1, 1, 2};
        logic [3:0] lsts [4] = '{4'b0000, 4'b0000, 4'b0010, 4'b0100};
        do_reset();
        vld  = 4'b0110;
        ordy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lst = lsts[i];
            dat = {$urandom, $urandom};
            tick();
            chks++;
            if (d_oi[2] !== exp_i[i] || d_ov[2] !== 1'b1) begin
                errs++;
                $display("FAIL lock_pkt beat %0d got vld=%b idx=%0d exp 1 %0d",
                         i, d_ov[2], d_oi[2], exp_i[i]);
            end
        end
        // Gap on the owner: the other requester must stay blocked.
        do_reset();
        vld = 4'b0110;
        lst = 4'b0000;
        tick();
        vld = 4'b0100;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chks++;
            if (d_rdy[2] !== 4'b0000) begin
                errs++;
                $display("FAIL lock_gap_rdy cyc %0d got %b exp 0000", i, d_rdy[2]);
            end
            step();
            chks++;
            if (d_ov[2] !== 1'b0) begin
                errs++;
                $display("FAIL lock_gap_vld cyc %0d got %b exp 0", i, d_ov[2]);
            end
        end
        vld = 4'b0110;
        lst = 4'b0010;
        @(negedge clk);
        chks++;
        if (d_rdy[2] !== 4'b0010) begin
            errs++;
            $display("FAIL lock_resume_rdy got %b exp 0010", d_rdy[2]);
        end
        step();
        vld = 4'h0;
        lst = 4'h0;
    endtask

    task automatic test_rst_locked();
        do_reset();
        vld  = 4'b1000;
        lst  = 4'b0000;
        ordy = 1'b1;
        tick();
        chks++;
        if (d_ov[2] !== 1'b1 || d_oi[2] !== 3) begin
            errs++;
            $display("FAIL rstlk_pre got vld=%b idx=%0d exp 1 3", d_ov[2], d_oi[2]);
        end
        rst  = 1'b1;
        vld  = 4'hF;
        lst  = 4'hF;
        ordy = 1'b0;
        @(negedge clk);
        chks++;
        if (d_rdy[2] !== 4'b0000) begin
            errs++;
            $display("FAIL rstlk_rdy got %b exp 0000", d_rdy[2]);
        end
        step();
        chks++;
        if (d_ov[2] !== 1'b0 || d_oi[2] !== 0) begin
            errs++;
            $display("FAIL rstlk_clear got vld=%b idx=%0d exp 0 0", d_ov[2], d_oi[2]);
        end
        rst  = 1'b0;
        ordy = 1'b1;
        tick();
        for (int c = 1; c < 3; c++) begin
            chks++;
            if (d_ov[c] !== 1'b1 || d_oi[c] !== 0) begin
                errs++;
                $display("FAIL rstlk_first c%0d got vld=%b idx=%0d exp 1 0",
                         c, d_ov[c], d_oi[c]);
            end
        end
        vld = 4'h0;
    endtask

    task automatic test_w1();
        logic [3:0] pd;
        do_reset();
        vld  = 4'b0001;
        lst  = 4'h0;
        ordy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dat[0] = 4'($urandom);
            lst[0] = 1'($urandom);
            pd = dat[0];
            tick();
            chks++;
            if (d_ov[3] !== 1'b1 || d_oi[3] !== 0 ||
                d_od[3] !== pd || d_ol[3] !== lst[0]) begin
                errs++;
                $display("FAIL w1_pass beat %0d got vld=%b idx=%0d dat=%h lst=%b exp 1 0 %h %b",
                         i, d_ov[3], d_oi[3], d_od[3], d_ol[3], pd, lst[0]);
            end
        end
        vld = 4'h0;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            vld  = 4'($urandom);
            lst  = 4'($urandom) & 4'($urandom);
            dat  = {$urandom, $urandom};
            ordy = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 59) == 0);
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                chks++;
                if (d_rdy[c] !== exp_rdy(c)) begin
                    errs++;
                    $display("FAIL rand_rdy c%0d cyc %0d got %b exp %b",
                             c, n, d_rdy[c], exp_rdy(c));
                end
                chks++;
                if (d_ov[c] !== m[c].ov || d_oi[c] !== m[c].oi ||
                    d_od[c] !== m[c].od || d_ol[c] !== m[c].ol) begin
                    errs++;
                    $display("FAIL rand_out c%0d cyc %0d got %b/%0d/%h/%b exp %b/%0d/%h/%b",
                             c, n, d_ov[c], d_oi[c], d_od[c], d_ol[c],
                             m[c].ov, m[c].oi, m[c].od, m[c].ol);
                end
            end
            step();
        end
        rst = 1'b0;
        vld = 4'h0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_pry();
        test_rr();
        test_stall();
        test_lock();
        test_rst_locked();
        test_w1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
